plru_ctrl: RTL

//  Replacement controller for an N-way set-associative cache: owns per-set tree-PLRU state
//  (NUM_WAYS-1 bits per set) and sequences read-modify-write of that state.
//  On a hit it records the accessed way; on a miss it selects the victim and records it.

---
 rtl/plru_pkg.sv | 68 ++++++
 rtl/plru_tree_logic.sv | 41 ++++
 rtl/plru_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/plru_pkg.sv
// Purpose: shared types and pure tree-PLRU helpers for the replacement controller.
// Latency: functions only, no state.
// Backpressure: n/a.
// Helpers work on a fixed maximum-width tree (up to 64 ways). The caller passes the
// real way count and zero-pads the unused upper bits.
package plru_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_UPDATE = 2'd2,
        ST_FLUSH  = 2'd3
    } plru_state_e;

    localparam int PLRU_MAX_WAYS = 64;
    localparam int PLRU_IDX_W    = 6;

    typedef logic [PLRU_MAX_WAYS-1:0] plru_vec_t;
    typedef logic [PLRU_IDX_W-1:0]    plru_way_t;

    // Walk from the root: bit 0 steps to the low child (2i+1), bit 1 to the high child (2i+2).
    // Once the node index passes the last internal node it is a leaf, and leaf - (ways-1) is the way.
    function automatic plru_way_t plru_victim(input plru_vec_t tree, input int num_ways);
        int node;
        node = 0;
        for (int l = 0; l < PLRU_IDX_W; l++) begin
            if (node < num_ways - 1) begin
                node = 2 * node + 1 + int'(tree[node[5:0]]);
            end
        end
        return plru_way_t'(node - (num_ways - 1));
    endfunction

    // Climb from the leaf of 'way' to the root. A low child (odd index) makes its parent
    // point high (1); a high child makes its parent point low (0).
    function automatic plru_vec_t plru_touch(input plru_vec_t tree, input plru_way_t way,
                                             input int num_ways);
        plru_vec_t t;
        int        node;
        int        parent;
        t    = tree;
        node = int'(way) + num_ways - 1;
        for (int l = 0; l < PLRU_IDX_W; l++) begin
            if (node > 0) begin
                parent           = (node - 1) >> 1;
                t[parent[5:0]]   = node[0];
                node             = parent;
            end
        end
        return t;
    endfunction

    // Lowest-index way whose valid bit is clear. Returns 0 if none (caller checks).
    function automatic plru_way_t first_invalid(input plru_vec_t valid, input int num_ways);
        plru_way_t way;
        logic      found;
        way   = '0;
        found = 1'b0;
        for (int i = 0; i < PLRU_MAX_WAYS; i++) begin
            if (i < num_ways && !found && !valid[i]) begin
                way   = plru_way_t'(i);
                found = 1'b1;
            end
        end
        return way;
    endfunction

endpackage

// File: rtl/plru_tree_logic.sv
// Purpose: combinational tree-PLRU victim select and next-tree for one set.
// Latency: purely combinational.
// Backpressure: none.
// Ports: tree (current set state), hit/way (touch way when hit), victim (tree walk),
//        sel_way (way to report and touch), next_tree (tree after touching sel_way).
module plru_tree_logic
    import plru_pkg::*;
#(
    parameter int NUM_WAYS = 4
) (
    input  logic [NUM_WAYS-2:0]         tree,
    input  logic                        hit,
    input  logic [$clog2(NUM_WAYS)-1:0] way,
    output logic [$clog2(NUM_WAYS)-1:0] victim,
    output logic [$clog2(NUM_WAYS)-1:0] sel_way,
    output logic [NUM_WAYS-2:0]         next_tree
);
    localparam int WW = $clog2(NUM_WAYS);

    plru_vec_t tree_ext;
    plru_vec_t next_ext;
    plru_way_t victim_ext;
    plru_way_t sel_ext;
    logic      unused_ext;

    always_comb begin
        tree_ext                 = '0;
        tree_ext[NUM_WAYS-2:0]   = tree;
        victim_ext               = plru_victim(tree_ext, NUM_WAYS);
        victim                   = victim_ext[WW-1:0];
        sel_way                  = hit ? way : victim;
        sel_ext                  = '0;
        sel_ext[WW-1:0]          = sel_way;
        next_ext                 = plru_touch(tree_ext, sel_ext, NUM_WAYS);
        next_tree                = next_ext[NUM_WAYS-2:0];
    end

    // Upper bits of the max-width helpers are padding only.
    assign unused_ext = ^{victim_ext, next_ext};

endmodule

// File: rtl/plru_ctrl.sv
// Purpose: per-set tree-PLRU state owner; serialised read-modify-write on hit/miss, set-by-set flush.
// Latency: request accepted at edge N gives a one-cycle rsp_valid two cycles later; 1 request per 3 cycles.
// Backpressure: req_ready only in IDLE without flush_req; rsp has none. Optional PLRU_INVALID_FIRST_EN
// adds the way_valid port: misses then pick the lowest invalid way before consulting the tree.
// Ports: clk0/rst0 (sync active-high), req_* request, way_valid (optional), flush_req/flush_busy,
//        rsp_valid/rsp_way response.
module plru_ctrl
    import plru_pkg::*;
#(
    parameter int NUM_WAYS = 4,
    parameter int NUM_SETS = 16
) (
    input  logic                        clk0,
    input  logic                        rst0,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [$clog2(NUM_SETS)-1:0] req_set,
    input  logic                        req_hit,
    input  logic [$clog2(NUM_WAYS)-1:0] req_way,
`ifdef PLRU_INVALID_FIRST_EN
    input  logic [NUM_WAYS-1:0]         way_valid,
`endif
    input  logic                        flush_req,
    output logic                        flush_busy,
    output logic                        rsp_valid,
    output logic [$clog2(NUM_WAYS)-1:0] rsp_way
);
    localparam int WW = $clog2(NUM_WAYS);
    localparam int SW = $clog2(NUM_SETS);
    localparam int TW = NUM_WAYS - 1;

    plru_state_e   state_q, state_d;
    logic [SW-1:0] set_q, set_d;
    logic          hit_q, hit_d;
    logic [WW-1:0] way_q, way_d;
    logic [TW-1:0] tree_rd_q, tree_rd_d;
    logic [SW-1:0] flush_cnt_q, flush_cnt_d;
    logic [TW-1:0] tree_q [NUM_SETS];
    logic [TW-1:0] tree_d [NUM_SETS];

    logic          eff_hit;
    logic [WW-1:0] eff_way;
    logic [WW-1:0] victim;
    logic [WW-1:0] sel_way;
    logic [TW-1:0] next_tree;

`ifdef PLRU_INVALID_FIRST_EN
    logic [NUM_WAYS-1:0] way_valid_q, way_valid_d;
    plru_vec_t           valid_ext;
    plru_way_t           inv_way_full;
    logic                unused_inv;
    assign unused_inv = ^inv_way_full;
`endif

    // A miss with an invalid way is presented to the tree logic as a hit on that way,
    // so the reported victim is also the way that gets touched.
    always_comb begin
        eff_hit = hit_q;
        eff_way = way_q;
`ifdef PLRU_INVALID_FIRST_EN
        valid_ext               = '1;
        valid_ext[NUM_WAYS-1:0] = way_valid_q;
        inv_way_full            = first_invalid(valid_ext, NUM_WAYS);
        if (!hit_q && !(&way_valid_q)) begin
            eff_hit = 1'b1;
            eff_way = inv_way_full[WW-1:0];
        end
`endif
    end

    plru_tree_logic #(.NUM_WAYS(NUM_WAYS)) u_tree_logic (
        .tree      (tree_rd_q),
        .hit       (eff_hit),
        .way       (eff_way),
        .victim    (victim),
        .sel_way   (sel_way),
        .next_tree (next_tree)
    );

    always_comb begin
        state_d     = state_q;
        set_d       = set_q;
        hit_d       = hit_q;
        way_d       = way_q;
        tree_rd_d   = tree_rd_q;
        flush_cnt_d = flush_cnt_q;
        tree_d      = tree_q;
`ifdef PLRU_INVALID_FIRST_EN
        way_valid_d = way_valid_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (flush_req) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = '0;
                end else if (req_valid) begin
                    state_d = ST_READ;
                    set_d   = req_set;
                    hit_d   = req_hit;
                    way_d   = req_way;
`ifdef PLRU_INVALID_FIRST_EN
                    way_valid_d = way_valid;
`endif
                end
            end
            ST_READ: begin
                tree_rd_d = tree_q[set_q];
                state_d   = ST_UPDATE;
            end
            ST_UPDATE: begin
                tree_d[set_q] = next_tree;
                state_d       = ST_IDLE;
            end
            ST_FLUSH: begin
                tree_d[flush_cnt_q] = '0;
                if (flush_cnt_q == SW'(NUM_SETS - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            state_q     <= ST_IDLE;
            set_q       <= '0;
            hit_q       <= 1'b0;
            way_q       <= '0;
            tree_rd_q   <= '0;
            flush_cnt_q <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                tree_q[s] <= '0;
            end
`ifdef PLRU_INVALID_FIRST_EN
            way_valid_q <= '1;
`endif
        end else begin
            state_q     <= state_d;
            set_q       <= set_d;
            hit_q       <= hit_d;
            way_q       <= way_d;
            tree_rd_q   <= tree_rd_d;
            flush_cnt_q <= flush_cnt_d;
            tree_q      <= tree_d;
`ifdef PLRU_INVALID_FIRST_EN
            way_valid_q <= way_valid_d;
`endif
        end
    end

    // rst0 during UPDATE aborts the access, so the response is suppressed that same cycle.
    assign req_ready  = (state_q == ST_IDLE) && !flush_req;
    assign flush_busy = (state_q == ST_FLUSH);
    assign rsp_valid  = (state_q == ST_UPDATE) && !rst0;
    assign rsp_way    = rsp_valid ? sel_way : '0;

endmodule
